// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: sequences an FFT core over a burst of frames.
// Sends one config word, passes NUM frames of N samples into the FFT input stream while
// generating input tlast, and snoops the FFT output stream to count frames, check output
// tlast framing and signal done once every issued frame has drained.
// Optional build macro FFT_CTRL_DRAIN_TIMEOUT_EN adds a 16-bit drain watchdog that drives
// the timeout output; without it timeout is tied low and DRAIN waits indefinitely.
module fft_frame_ctrl #(
  parameter int unsigned LOG2_NMAX = 10,
  parameter int unsigned DIN_W     = 32,
  parameter int unsigned CFG_W     = 16
) (
  input  logic             m_axis_aclk_0,
  input  logic             m_axis_aresetn_0,
  input  logic             start,
  input  logic             abort,
  input  logic [4:0]       nfft_log2,
  input  logic             fwd_inv,
  input  logic [15:0]      num_frames,
  input  logic [DIN_W-1:0] src_tdata,
  input  logic             src_tvalid,
  output logic             src_tready,
  output logic [DIN_W-1:0] s_axis_data_tdata,
  output logic             s_axis_data_tvalid,
  output logic             s_axis_data_tlast,
  input  logic             s_axis_data_tready,
  output logic [CFG_W-1:0] s_axis_config_tdata,
  output logic             s_axis_config_tvalid,
  input  logic             s_axis_config_tready,
  input  logic             fft_out_tvalid,
  input  logic             fft_out_tready,
  input  logic             fft_out_tlast,
  output logic             busy,
  output logic             done,
  output logic [15:0]      frames_out,
  output logic             tlast_err,
  output logic             timeout
);

  typedef enum logic [1:0] {StIdle, StCfg, StStream, StDrain} state_e;

  state_e               state_q, state_d;
  logic [4:0]           log2_q, log2_d;
  logic                 fwd_q, fwd_d;
  logic [15:0]          num_q, num_d;
  logic [LOG2_NMAX-1:0] in_cnt_q, in_cnt_d;
  logic [LOG2_NMAX-1:0] out_cnt_q, out_cnt_d;
  logic [15:0]          frames_in_q, frames_in_d;
  logic [15:0]          frames_out_q, frames_out_d;
  logic                 abort_pend_q, abort_pend_d;
  logic                 tlast_err_q, tlast_err_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
`ifdef FFT_CTRL_DRAIN_TIMEOUT_EN
  logic [15:0]          wd_q, wd_d;
  logic                 timeout_q, timeout_d;
`endif

  logic [4:0]           log2_clamp;
  logic [LOG2_NMAX-1:0] last_idx;
  logic [CFG_W-1:0]     cfg_word;
  logic                 stream, in_hs, in_last, out_beat, cfg_hs;

  // Clamp the requested transform size into the supported range.
  always_comb begin
    log2_clamp = nfft_log2;
    if (nfft_log2 < 5'd3) begin
      log2_clamp = 5'd3;
    end else if (nfft_log2 > 5'(LOG2_NMAX)) begin
      log2_clamp = 5'(LOG2_NMAX);
    end
  end

  // N-1 as a mask; a shift of LOG2_NMAX clears every bit, giving all ones.
  assign last_idx = ~({LOG2_NMAX{1'b1}} << log2_q);

  // Config word: size in [4:0], direction in [8].
  always_comb begin
    cfg_word    = '0;
    cfg_word[4:0] = log2_q;
    cfg_word[8] = fwd_q;
  end

  assign stream   = (state_q == StStream);
  assign in_hs    = stream & src_tvalid & s_axis_data_tready;
  assign in_last  = in_hs & (in_cnt_q == last_idx);
  assign out_beat = (state_q != StIdle) & fft_out_tvalid & fft_out_tready;
  assign cfg_hs   = (state_q == StCfg) & s_axis_config_tready;

  // Zero-latency pass-through while streaming; everything gated off otherwise.
  assign s_axis_data_tvalid   = stream & src_tvalid;
  assign src_tready           = stream & s_axis_data_tready;
  assign s_axis_data_tdata    = stream ? src_tdata : '0;
  assign s_axis_data_tlast    = stream & (in_cnt_q == last_idx);
  assign s_axis_config_tvalid = (state_q == StCfg);
  assign s_axis_config_tdata  = (state_q == StCfg) ? cfg_word : '0;

  assign busy       = busy_q;
  assign done       = done_q;
  assign frames_out = frames_out_q;
  assign tlast_err  = tlast_err_q;
`ifdef FFT_CTRL_DRAIN_TIMEOUT_EN
  assign timeout    = timeout_q;
`else
  assign timeout    = 1'b0;
`endif

  // Next-state: run sequencing, input framing and output snoop.
  always_comb begin
    state_d      = state_q;
    log2_d       = log2_q;
    fwd_d        = fwd_q;
    num_d        = num_q;
    in_cnt_d     = in_cnt_q;
    out_cnt_d    = out_cnt_q;
    frames_in_d  = frames_in_q;
    frames_out_d = frames_out_q;
    abort_pend_d = abort_pend_q;
    tlast_err_d  = tlast_err_q;
    done_d       = 1'b0;
`ifdef FFT_CTRL_DRAIN_TIMEOUT_EN
    wd_d         = '0;
    timeout_d    = timeout_q;
`endif

    // Output snoop; a tlast always resyncs the beat counter.
    if (out_beat) begin
      if (fft_out_tlast) begin
        if (out_cnt_q != last_idx) tlast_err_d = 1'b1;
        out_cnt_d    = '0;
        frames_out_d = frames_out_q + 16'd1;
      end else if (out_cnt_q == last_idx) begin
        tlast_err_d = 1'b1;
        out_cnt_d   = '0;
      end else begin
        out_cnt_d = out_cnt_q + LOG2_NMAX'(1);
      end
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          log2_d       = log2_clamp;
          fwd_d        = fwd_inv;
          num_d        = num_frames;
          in_cnt_d     = '0;
          out_cnt_d    = '0;
          frames_in_d  = '0;
          frames_out_d = '0;
          abort_pend_d = 1'b0;
          tlast_err_d  = 1'b0;
`ifdef FFT_CTRL_DRAIN_TIMEOUT_EN
          timeout_d    = 1'b0;
`endif
          state_d      = StCfg;
        end
      end
      StCfg: begin
        if (abort) abort_pend_d = 1'b1;
        if (cfg_hs) state_d = (abort_pend_q | abort) ? StDrain : StStream;
      end
      StStream: begin
        if (abort) abort_pend_d = 1'b1;
        if (in_last) begin
          in_cnt_d    = '0;
          frames_in_d = frames_in_q + 16'd1;
          // Aborts only take effect on a frame boundary.
          if (((frames_in_q + 16'd1 == num_q) && (num_q != 16'd0)) || abort_pend_q || abort) begin
            state_d = StDrain;
          end
        end else if (in_hs) begin
          in_cnt_d = in_cnt_q + LOG2_NMAX'(1);
        end
      end
      StDrain: begin
        if (frames_out_q == frames_in_q) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
`ifdef FFT_CTRL_DRAIN_TIMEOUT_EN
        else if (out_beat) begin
          wd_d = '0;
        end else if (wd_q == 16'hFFFF) begin
          timeout_d = 1'b1;
          done_d    = 1'b1;
          state_d   = StIdle;
        end else begin
          wd_d = wd_q + 16'd1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  // State and counter registers.
  always_ff @(posedge m_axis_aclk_0 or negedge m_axis_aresetn_0) begin
    if (!m_axis_aresetn_0) begin
      state_q      <= StIdle;
      log2_q       <= '0;
      fwd_q        <= 1'b0;
      num_q        <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      frames_in_q  <= '0;
      frames_out_q <= '0;
      abort_pend_q <= 1'b0;
      tlast_err_q  <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
`ifdef FFT_CTRL_DRAIN_TIMEOUT_EN
      wd_q         <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      log2_q       <= log2_d;
      fwd_q        <= fwd_d;
      num_q        <= num_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      frames_in_q  <= frames_in_d;
      frames_out_q <= frames_out_d;
      abort_pend_q <= abort_pend_d;
      tlast_err_q  <= tlast_err_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
`ifdef FFT_CTRL_DRAIN_TIMEOUT_EN
      wd_q         <= wd_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Testbench for fft_frame_ctrl: randomized source/sink handshakes checked against a
// frame-level reference model (config word arithmetic, tlast every N beats, frame counts).
module tb_fft_frame_ctrl;
  localparam int LOG2_NMAX = 10;
  localparam int DIN_W = 32;
  localparam int CFG_W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             start = 0, abort = 0, fwd_inv = 0;
  logic [4:0]       nfft_log2 = '0;
  logic [15:0]      num_frames = '0;
  logic [DIN_W-1:0] src_tdata = '0;
  logic             src_tvalid = 0, src_tready;
  logic [DIN_W-1:0] s_axis_data_tdata;
  logic             s_axis_data_tvalid, s_axis_data_tlast, s_axis_data_tready = 0;
  logic [CFG_W-1:0] s_axis_config_tdata;
  logic             s_axis_config_tvalid, s_axis_config_tready = 0;
  logic             fft_out_tvalid = 0, fft_out_tready = 0, fft_out_tlast = 0;
  logic             busy, done, tlast_err, timeout;
  logic [15:0]      frames_out;

  int total = 0;
  int bad = 0;
  int olen[$];

  fft_frame_ctrl #(.LOG2_NMAX(LOG2_NMAX), .DIN_W(DIN_W), .CFG_W(CFG_W)) dut (
    .m_axis_aclk_0(clk), .m_axis_aresetn_0(rst_n),
    .start(start), .abort(abort), .nfft_log2(nfft_log2), .fwd_inv(fwd_inv),
    .num_frames(num_frames),
    .src_tdata(src_tdata), .src_tvalid(src_tvalid), .src_tready(src_tready),
    .s_axis_data_tdata(s_axis_data_tdata), .s_axis_data_tvalid(s_axis_data_tvalid),
    .s_axis_data_tlast(s_axis_data_tlast), .s_axis_data_tready(s_axis_data_tready),
    .s_axis_config_tdata(s_axis_config_tdata), .s_axis_config_tvalid(s_axis_config_tvalid),
    .s_axis_config_tready(s_axis_config_tready),
    .fft_out_tvalid(fft_out_tvalid), .fft_out_tready(fft_out_tready),
    .fft_out_tlast(fft_out_tlast),
    .busy(busy), .done(done), .frames_out(frames_out), .tlast_err(tlast_err),
    .timeout(timeout)
  );

  // ---------------- reference model ----------------
  function automatic int model_log2(input int req);
    if (req < 3) return 3;
    if (req > LOG2_NMAX) return LOG2_NMAX;
    return req;
  endfunction

  function automatic logic [15:0] model_cfg(input int req, input bit fwd);
    return 16'(model_log2(req)) | (fwd ? 16'h0100 : 16'h0000);
  endfunction

  // ---------------- stimulus helpers (observe only; tests compare) ----------------
  // Pulse start, hold config tready low for 'hold' cycles, then handshake.
  task automatic do_config(input int l2, input bit fwd, input int nf, input int hold,
                           input bit abrt, output logic [15:0] word, output int unstable);
    unstable = 0;
    start = 1; nfft_log2 = 5'(l2); fwd_inv = fwd; num_frames = 16'(nf);
    @(negedge clk);
    start = 0; abort = abrt;
    nfft_log2 = 5'($urandom); fwd_inv = 1'($urandom); num_frames = 16'($urandom);
    #1 word = s_axis_config_tdata;
    for (int i = 0; i <= hold; i++) begin
      s_axis_config_tready = (i == hold);
      #1;
      if (s_axis_config_tvalid !== 1'b1 || s_axis_config_tdata !== word) unstable++;
      @(negedge clk);
    end
    s_axis_config_tready = 0; abort = 0;
  endtask

  task automatic drive_input(input int n_expect, input int n, input bit rnd, input int abort_at,
                             input int start_at, output int beats, output int pass_bad,
                             output int tlast_bad, output int extra, output int cycles,
                             output int dn);
    beats = 0; pass_bad = 0; tlast_bad = 0; extra = 0; cycles = 0; dn = 0;
    for (int c = 0; c < n_expect * 8 + 100 && beats < n_expect; c++) begin
      src_tvalid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_axis_data_tready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      src_tdata = $urandom;
      abort = (beats == abort_at);
      start = (beats == start_at);
      #1;
      if (s_axis_data_tvalid !== src_tvalid || src_tready !== s_axis_data_tready ||
          s_axis_data_tdata !== src_tdata) pass_bad++;
      if (s_axis_data_tlast !== (((beats + 1) % n) == 0)) tlast_bad++;
      if (done === 1'b1) dn++;
      if (src_tvalid && src_tready === 1'b1) beats++;
      cycles++;
      @(negedge clk);
    end
    abort = 0; start = 0;
    for (int c = 0; c < 6; c++) begin
      src_tvalid = 1; s_axis_data_tready = 1;
      #1;
      if (s_axis_data_tvalid !== 1'b0 || src_tready !== 1'b0) extra++;
      if (done === 1'b1) dn++;
      @(negedge clk);
    end
    src_tvalid = 0; s_axis_data_tready = 0;
  endtask

  // Emit output frames of lengths olen[] (tlast on each frame's last beat).
  task automatic drive_output(input bit rnd, output int done_cnt, output int busy_bad,
                              output int fo, output int early);
    int f, pos;
    f = 0; pos = 0; done_cnt = 0; busy_bad = 0; fo = -1; early = 0;
    for (int c = 0; c < 4000 && f < olen.size(); c++) begin
      fft_out_tvalid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      fft_out_tready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      fft_out_tlast = (pos == olen[f] - 1);
      #1;
      if (done === 1'b1) begin done_cnt++; early++; end
      if (fft_out_tvalid && fft_out_tready) begin
        if (pos == olen[f] - 1) begin pos = 0; f++; end else pos++;
      end
      @(negedge clk);
    end
    fft_out_tvalid = 0; fft_out_tready = 0; fft_out_tlast = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (done === 1'b1) begin
        done_cnt++;
        if (busy !== 1'b0) busy_bad++;
        fo = int'(frames_out);
      end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    total++;
    if ({busy, done, tlast_err, timeout, s_axis_config_tvalid, s_axis_data_tvalid,
         src_tready, s_axis_data_tlast} !== 8'h00) begin
      bad++; $display("FAIL reset_flags got=%b exp=00000000", {busy, done, tlast_err, timeout,
        s_axis_config_tvalid, s_axis_data_tvalid, src_tready, s_axis_data_tlast});
    end
    total++;
    if (frames_out !== 16'd0) begin bad++; $display("FAIL reset_frames_out got=%0d exp=0", frames_out); end
    total++;
    if (s_axis_config_tdata !== 16'h0 || s_axis_data_tdata !== 32'h0) begin
      bad++; $display("FAIL reset_tdata got=%h/%h exp=0/0", s_axis_config_tdata, s_axis_data_tdata);
    end
  endtask

  task automatic test_basic_run();
    logic [15:0] w; int un, b, pb, tb, ex, cy, dn, dc, bb, fo, er;
    do_config(6, 1, 2, 5, 0, w, un);
    total++;
    if (w !== model_cfg(6, 1)) begin bad++; $display("FAIL cfg_word got=%h exp=%h", w, model_cfg(6, 1)); end
    total++;
    if (un !== 0) begin bad++; $display("FAIL cfg_stable got=%0d exp=0", un); end
    drive_input(128, 64, 0, -1, -1, b, pb, tb, ex, cy, dn);
    total++;
    if (b !== 128) begin bad++; $display("FAIL in_beats got=%0d exp=128", b); end
    total++;
    if (pb !== 0 || tb !== 0) begin bad++; $display("FAIL in_pass_tlast got=%0d/%0d exp=0/0", pb, tb); end
    total++;
    if (cy !== 128) begin bad++; $display("FAIL in_no_gap got=%0d exp=128", cy); end
    total++;
    if (ex !== 0 || dn !== 0 || busy !== 1'b1) begin
      bad++; $display("FAIL in_drain got=extra%0d done%0d busy%b exp=0/0/1", ex, dn, busy);
    end
    olen = '{64, 64};
    drive_output(1, dc, bb, fo, er);
    total++;
    if (dc !== 1 || er !== 0) begin bad++; $display("FAIL out_done got=%0d early%0d exp=1/0", dc, er); end
    total++;
    if (bb !== 0 || fo !== 2) begin bad++; $display("FAIL out_busy_fo got=%0d/%0d exp=0/2", bb, fo); end
    total++;
    if (tlast_err !== 1'b0) begin bad++; $display("FAIL out_tlast_err got=%b exp=0", tlast_err); end
  endtask

  task automatic test_random_runs();
    logic [15:0] w; int un, b, pb, tb, ex, cy, dn, dc, bb, fo, er, l2, nf, n; bit fw;
    for (int r = 0; r < 4; r++) begin
      l2 = $urandom_range(0, 5); fw = 1'($urandom); nf = $urandom_range(1, 3);
      n = 1 << model_log2(l2);
      do_config(l2, fw, nf, $urandom_range(0, 3), 0, w, un);
      total++;
      if (w !== model_cfg(l2, fw) || un !== 0) begin
        bad++; $display("FAIL rnd_cfg run%0d got=%h un%0d exp=%h", r, w, un, model_cfg(l2, fw));
      end
      drive_input(nf * n, n, 1, -1, $urandom_range(1, nf * n - 1), b, pb, tb, ex, cy, dn);
      total++;
      if (b !== nf * n || pb !== 0 || tb !== 0 || ex !== 0 || dn !== 0) begin
        bad++; $display("FAIL rnd_in run%0d got=%0d pb%0d tb%0d ex%0d dn%0d exp=%0d", r, b, pb, tb,
                        ex, dn, nf * n);
      end
      olen = {};
      for (int f = 0; f < nf; f++) olen.push_back(n);
      drive_output(1, dc, bb, fo, er);
      total++;
      if (dc !== 1 || er !== 0 || bb !== 0 || fo !== nf || tlast_err !== 1'b0) begin
        bad++; $display("FAIL rnd_out run%0d got=done%0d early%0d fo%0d err%b exp=1/0/%0d/0", r, dc,
                        er, fo, tlast_err, nf);
      end
    end
  endtask

  task automatic test_abort();
    logic [15:0] w; int un, b, pb, tb, ex, cy, dn, dc, bb, fo, er, ab, nexp;
    ab = 2 * 64 + 20;
    nexp = (ab / 64 + 1) * 64;
    do_config(6, 0, 0, 0, 0, w, un);
    drive_input(nexp, 64, 0, ab, 50, b, pb, tb, ex, cy, dn);
    total++;
    if (b !== nexp || ex !== 0 || tb !== 0) begin
      bad++; $display("FAIL abort_in got=%0d ex%0d tb%0d exp=%0d/0/0", b, ex, tb, nexp);
    end
    olen = '{64, 64, 64};
    drive_output(1, dc, bb, fo, er);
    total++;
    if (dc !== 1 || er !== 0 || fo !== 3) begin
      bad++; $display("FAIL abort_out got=done%0d early%0d fo%0d exp=1/0/3", dc, er, fo);
    end
  endtask

  task automatic test_abort_in_cfg();
    logic [15:0] w; int un, dc, rd;
    do_config(15, 1, 5, 2, 1, w, un);
    total++;
    if (w !== model_cfg(15, 1) || un !== 0) begin
      bad++; $display("FAIL cfg_clamp_hi got=%h un%0d exp=%h", w, un, model_cfg(15, 1));
    end
    dc = 0; rd = 0;
    for (int c = 0; c < 6; c++) begin
      src_tvalid = 1; s_axis_data_tready = 1;
      #1;
      if (done === 1'b1) dc++;
      if (src_tready === 1'b1 || s_axis_data_tvalid === 1'b1) rd++;
      @(negedge clk);
    end
    src_tvalid = 0; s_axis_data_tready = 0;
    total++;
    if (dc !== 1 || rd !== 0 || frames_out !== 16'd0) begin
      bad++; $display("FAIL abort_cfg got=done%0d rd%0d fo%0d exp=1/0/0", dc, rd, frames_out);
    end
  endtask

  task automatic test_framing_err_and_clamp();
    logic [15:0] w; int un, b, pb, tb, ex, cy, dn, dc, bb, fo, er;
    do_config(6, 1, 2, 0, 0, w, un);
    drive_input(128, 64, 1, -1, -1, b, pb, tb, ex, cy, dn);
    olen = '{41, 64};
    drive_output(0, dc, bb, fo, er);
    total++;
    if (tlast_err !== 1'b1) begin bad++; $display("FAIL ferr_flag got=%b exp=1", tlast_err); end
    total++;
    if (dc !== 1 || fo !== 2 || er !== 0) begin
      bad++; $display("FAIL ferr_done got=done%0d fo%0d early%0d exp=1/2/0", dc, fo, er);
    end
    do_config(2, 0, 1, 1, 0, w, un);
    total++;
    if (w[4:0] !== 5'd3 || w !== model_cfg(2, 0)) begin
      bad++; $display("FAIL clamp_lo got=%h exp=%h", w, model_cfg(2, 0));
    end
    total++;
    if (tlast_err !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", tlast_err); end
    drive_input(8, 8, 1, -1, -1, b, pb, tb, ex, cy, dn);
    total++;
    if (b !== 8 || tb !== 0 || ex !== 0) begin
      bad++; $display("FAIL clamp_in got=%0d tb%0d ex%0d exp=8/0/0", b, tb, ex);
    end
    olen = '{8};
    drive_output(1, dc, bb, fo, er);
    total++;
    if (dc !== 1 || fo !== 1 || tlast_err !== 1'b0) begin
      bad++; $display("FAIL clamp_out got=done%0d fo%0d err%b exp=1/1/0", dc, fo, tlast_err);
    end
  endtask

  task automatic test_reset_mid_stream();
    logic [15:0] w; int un;
    do_config(4, 1, 3, 0, 0, w, un);
    src_tvalid = 1; s_axis_data_tready = 1; src_tdata = 32'hA5A5_0001;
    // Premature output tlast at beat 0 flags an error and counts a frame.
    fft_out_tvalid = 1; fft_out_tready = 1; fft_out_tlast = 1;
    @(negedge clk);
    fft_out_tvalid = 0; fft_out_tready = 0; fft_out_tlast = 0;
    repeat (4) @(negedge clk);
    total++;
    if (tlast_err !== 1'b1 || frames_out !== 16'd1) begin
      bad++; $display("FAIL early_tlast got=err%b fo%0d exp=1/1", tlast_err, frames_out);
    end
    #2 rst_n = 0;
    #1;
    total++;
    if ({busy, done, tlast_err, timeout, s_axis_config_tvalid, s_axis_data_tvalid, src_tready,
         s_axis_data_tlast} !== 8'h00 || frames_out !== 16'd0 || s_axis_data_tdata !== 32'h0) begin
      bad++; $display("FAIL async_reset got=%b fo%0d exp=00000000/0", {busy, done, tlast_err,
        timeout, s_axis_config_tvalid, s_axis_data_tvalid, src_tready, s_axis_data_tlast},
        frames_out);
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || s_axis_config_tvalid !== 1'b0 || src_tready !== 1'b0) begin
      bad++; $display("FAIL post_reset_idle got=%b%b%b exp=000", busy, s_axis_config_tvalid, src_tready);
    end
    src_tvalid = 0; s_axis_data_tready = 0;
    @(negedge clk);
  endtask

  task automatic test_drain_wait();
    logic [15:0] w; int un, b, pb, tb, ex, cy, dn, cnt;
    do_config(3, 0, 1, 0, 0, w, un);
    drive_input(8, 8, 0, -1, -1, b, pb, tb, ex, cy, dn);
`ifdef FFT_CTRL_DRAIN_TIMEOUT_EN
    cnt = 0;
    while (done !== 1'b1 && cnt < 70000) begin @(negedge clk); #1; cnt++; end
    total++;
    if (done !== 1'b1 || timeout !== 1'b1 || cnt < 65520 || cnt > 65545) begin
      bad++; $display("FAIL drain_timeout got=done%b to%b cyc%0d exp=1/1/~65535", done, timeout, cnt);
    end
    @(negedge clk);
`else
    begin
      int dc, bb, fo, er;
      cnt = 0;
      for (int c = 0; c < 50; c++) begin #1; if (done === 1'b1) cnt++; @(negedge clk); end
      total++;
      if (cnt !== 0 || timeout !== 1'b0 || busy !== 1'b1) begin
        bad++; $display("FAIL drain_wait got=done%0d to%b busy%b exp=0/0/1", cnt, timeout, busy);
      end
      olen = '{8};
      drive_output(0, dc, bb, fo, er);
      total++;
      if (dc !== 1 || fo !== 1) begin bad++; $display("FAIL drain_release got=%0d/%0d exp=1/1", dc, fo); end
    end
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL global_time_limit got=expired exp=finish");
    $fatal(1);
  end

  initial begin
    src_tvalid = 1; src_tdata = 32'hDEAD_BEEF; s_axis_data_tready = 1;
    repeat (3) @(negedge clk);
    #1;
    test_reset();
    src_tvalid = 0; s_axis_data_tready = 0;
    rst_n = 1;
    @(negedge clk);
    test_reset();
    test_basic_run();
    test_random_runs();
    test_abort();
    test_abort_in_cfg();
    test_framing_err_and_clamp();
    test_reset_mid_stream();
    test_drain_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
